// File: rtl/seqdet_sched.sv
// Round-robin front end for a shared bit-serial Moore "1011" detector: accepts a word from
// one of two requesters, clears the detector, shifts the word MSB first and counts the hits.
module seqdet_sched #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [WORD_W-1:0] req_word0,
    input  logic [WORD_W-1:0] req_word1,
    output logic [1:0]        req_ready,
    output logic              ser_bit,
    output logic              ser_en,
    output logic              det_clr,
    input  logic              det_in,
    output logic              done,
    output logic              done_id,
    output logic [CNT_W-1:0]  hit_count
);

    localparam int BIDX_W = $clog2(WORD_W);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WORD_W-1:0]   word_q;
    logic                id_q;
    logic                last_id;
    logic [BIDX_W-1:0]   bit_idx;
    logic [CNT_W-1:0]    run_cnt;
    logic [CNT_W-1:0]    run_next;
    logic [CNT_W-1:0]    hit_count_q;
    logic                done_id_q;
    logic                grant_valid;
    logic                grant_id;
    logic                sample;

    // Handshake: a requester holds req_valid and its word until it sees its req_ready bit;
    // req_ready is a one-cycle, one-hot strobe raised only in IDLE, and the word is taken
    // on that same clock edge.
    always_comb begin
        state_next  = state;
        req_ready   = 2'b00;
        ser_bit     = 1'b0;
        ser_en      = 1'b0;
        det_clr     = 1'b0;
        done        = 1'b0;
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        sample      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid != 2'b00 && !reset) begin
                    grant_valid = 1'b1;
                    grant_id    = (req_valid == 2'b11) ? ~last_id : req_valid[1];
                    req_ready   = grant_id ? 2'b10 : 2'b01;
                    state_next  = CLEAR;
                end
            end
            CLEAR: begin
                det_clr    = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                ser_en  = 1'b1;
                ser_bit = word_q[bit_idx];
                // The first shift cycle still shows the freshly cleared detector.
                sample  = (bit_idx != BIDX_W'(WORD_W - 1));
                if (bit_idx == '0) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                sample     = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        run_next = run_cnt;
        if (sample && det_in && (run_cnt != {CNT_W{1'b1}})) begin
            run_next = run_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            word_q      <= '0;
            id_q        <= 1'b0;
            last_id     <= 1'b1;
            bit_idx     <= '0;
            run_cnt     <= '0;
            hit_count_q <= '0;
            done_id_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_valid) begin
                word_q  <= grant_id ? req_word1 : req_word0;
                id_q    <= grant_id;
                last_id <= grant_id;
            end
            case (state)
                CLEAR: begin
                    bit_idx <= BIDX_W'(WORD_W - 1);
                    run_cnt <= '0;
                end
                SHIFT: begin
                    bit_idx <= bit_idx - 1'b1;
                    run_cnt <= run_next;
                end
                DRAIN: begin
                    // Results are loaded as DONE is entered so they are valid alongside done.
                    run_cnt     <= run_next;
                    hit_count_q <= run_next;
                    done_id_q   <= id_q;
                end
                default: ;
            endcase
        end
    end

    assign hit_count = hit_count_q;
    assign done_id   = done_id_q;

endmodule

// File: tb/tb_seqdet_sched.sv
// Bench for seqdet_sched: a behavioural Moore "1011" detector drives det_in, and a
// frame-level model predicts every output cycle by cycle from the accept time.
module tb_seqdet_sched;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;

    logic [1:0]  req_valid8 = 2'b00;
    logic [7:0]  req_word0_8 = 8'h00;
    logic [7:0]  req_word1_8 = 8'h00;
    logic [1:0]  req_ready8;
    logic        ser_bit8, ser_en8, det_clr8, det_in8, done8, done_id8;
    logic [3:0]  hit_count8;

    logic [1:0]  req_valid16 = 2'b00;
    logic [15:0] req_word0_16 = 16'h0000;
    logic [15:0] req_word1_16 = 16'h0000;
    logic [1:0]  req_ready16;
    logic        ser_bit16, ser_en16, det_clr16, det_in16, done16, done_id16;
    logic [1:0]  hit_count16;

    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    seqdet_sched #(.WORD_W(8), .CNT_W(4)) u_dut8 (
        .clock(clock), .reset(reset), .req_valid(req_valid8),
        .req_word0(req_word0_8), .req_word1(req_word1_8), .req_ready(req_ready8),
        .ser_bit(ser_bit8), .ser_en(ser_en8), .det_clr(det_clr8), .det_in(det_in8),
        .done(done8), .done_id(done_id8), .hit_count(hit_count8)
    );

    seqdet_sched #(.WORD_W(16), .CNT_W(2)) u_dut16 (
        .clock(clock), .reset(reset), .req_valid(req_valid16),
        .req_word0(req_word0_16), .req_word1(req_word1_16), .req_ready(req_ready16),
        .ser_bit(ser_bit16), .ser_en(ser_en16), .det_clr(det_clr16), .det_in(det_in16),
        .done(done16), .done_id(done_id16), .hit_count(hit_count16)
    );

    // Moore detector environment: 0=Zero 1="1" 2="10" 3="101" 4="1011" (output high).
    function automatic int det_step(input int s, input logic b);
        case (s)
            0: return b ? 1 : 0;
            1: return b ? 1 : 2;
            2: return b ? 3 : 0;
            3: return b ? 4 : 2;
            default: return b ? 1 : 2;
        endcase
    endfunction

    int ds8 = 0;
    int ds16 = 0;
    always @(posedge clock) ds8  <= det_clr8  ? 0 : det_step(ds8, ser_bit8);
    always @(posedge clock) ds16 <= det_clr16 ? 0 : det_step(ds16, ser_bit16);
    assign det_in8  = (ds8 == 4);
    assign det_in16 = (ds16 == 4);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Overlapping "1011" windows in the word, MSB first, saturated to 4 bits.
    function automatic logic [3:0] hits_of(input logic [7:0] w);
        int c;
        c = 0;
        for (int i = 7; i >= 3; i--) begin
            if (w[i -: 4] == 4'b1011) c++;
        end
        return (c > 15) ? 4'd15 : 4'(c);
    endfunction

    // Frame-level model: m_d is the cycle offset from the accept cycle.
    logic       m_busy = 1'b0;
    int         m_d = 0;
    logic [7:0] m_word = 8'h00;
    logic       m_id = 1'b0;
    logic       m_last = 1'b1;
    logic [3:0] m_hit = 4'd0;
    logic       m_did = 1'b0;

    logic [1:0] e_ready;
    logic       e_clr, e_en, e_bit, e_done, e_did, m_grant, m_g;
    logic [3:0] e_hit;

    logic [7:0] ser_cap = 8'h00;
    int         clr_cyc = -1;
    int         done_cnt = 0;
    int         ready_cnt = 0;

    always @(negedge clock) begin
        if (chk_en) begin
            e_ready = 2'b00; e_clr = 1'b0; e_en = 1'b0; e_bit = 1'b0; e_done = 1'b0;
            e_hit = m_hit; e_did = m_did; m_grant = 1'b0; m_g = 1'b0;
            if (!m_busy) begin
                if (req_valid8 != 2'b00 && !reset) begin
                    m_grant = 1'b1;
                    m_g     = (req_valid8 == 2'b11) ? ~m_last : req_valid8[1];
                    e_ready = m_g ? 2'b10 : 2'b01;
                end
            end else begin
                if (m_d == 1) e_clr = 1'b1;
                if (m_d >= 2 && m_d <= 9) begin
                    e_en  = 1'b1;
                    e_bit = m_word[9 - m_d];
                end
                if (m_d == 11) begin
                    e_done = 1'b1;
                    e_hit  = hits_of(m_word);
                    e_did  = m_id;
                end
            end
            chk("req_ready", 32'(req_ready8), 32'(e_ready));
            chk("det_clr", 32'(det_clr8), 32'(e_clr));
            chk("ser_en", 32'(ser_en8), 32'(e_en));
            chk("ser_bit", 32'(ser_bit8), 32'(e_bit));
            chk("done", 32'(done8), 32'(e_done));
            chk("hit_count", 32'(hit_count8), 32'(e_hit));
            chk("done_id", 32'(done_id8), 32'(e_did));

            if (ser_en8) ser_cap = {ser_cap[6:0], ser_bit8};
            if (det_clr8) clr_cyc = cyc;
            if (done8) done_cnt++;
            if (req_ready8 != 2'b00) ready_cnt++;

            if (reset) begin
                m_busy = 1'b0; m_last = 1'b1; m_hit = 4'd0; m_did = 1'b0;
            end else if (m_grant) begin
                m_busy = 1'b1; m_d = 1; m_id = m_g; m_last = m_g;
                m_word = m_g ? req_word1_8 : req_word0_8;
            end else if (m_busy) begin
                if (m_d == 11) begin
                    m_busy = 1'b0; m_hit = e_hit; m_did = e_did;
                end else begin
                    m_d++;
                end
            end
        end
    end

    task automatic wait_accept(output int t0, output logic [1:0] g);
        t0 = -1;
        g  = 2'b00;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (req_ready8 != 2'b00) begin
                t0 = cyc;
                g  = req_ready8;
                break;
            end
        end
        if (t0 < 0) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
    endtask

    task automatic wait_done(output int td, output logic [3:0] h, output logic id);
        td = -1;
        h  = 4'd0;
        id = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done8) begin
                td = cyc;
                h  = hit_count8;
                id = done_id8;
                break;
            end
        end
        if (td < 0) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
    endtask

    initial begin
        int         t0, td, t_prev, dc, rc;
        logic [1:0] g;
        logic [3:0] h;
        logic       id;
        logic [1:0] exp_g[3];
        logic [3:0] exp_h[3];

        repeat (2) @(posedge clock);
        #1;
        chk_en = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;

        @(negedge clock);
        chk("rst_hit_count", 32'(hit_count8), 32'd0);
        chk("rst_done_id", 32'(done_id8), 32'd0);
        chk("rst_ready", 32'(req_ready8), 32'd0);
        chk("rst_hit_count16", 32'(hit_count16), 32'd0);
        @(posedge clock); #1;

        // Frame on requester 0 with two overlapping matches.
        req_word0_8 = 8'b1011_0110;
        req_valid8  = 2'b01;
        wait_accept(t0, g);
        req_valid8 = 2'b00;
        chk("a_grant", 32'(g), 32'h1);
        wait_done(td, h, id);
        chk("a_clr_cycle", 32'(clr_cyc - t0), 32'd1);
        chk("a_latency", 32'(td - t0), 32'd11);
        chk("a_ser_bits", 32'(ser_cap), 32'hB6);
        chk("a_hits", 32'(h), 32'd2);
        chk("a_id", 32'(id), 32'd0);

        // Requester 1 with no matches in all-zero and all-one words.
        req_word1_8 = 8'h00;
        req_valid8  = 2'b10;
        wait_accept(t0, g);
        req_valid8 = 2'b00;
        chk("b0_grant", 32'(g), 32'h2);
        wait_done(td, h, id);
        chk("b0_hits", 32'(h), 32'd0);
        chk("b0_id", 32'(id), 32'd1);
        req_word1_8 = 8'hFF;
        req_valid8  = 2'b10;
        wait_accept(t0, g);
        req_valid8 = 2'b00;
        wait_done(td, h, id);
        chk("b1_hits", 32'(h), 32'd0);
        chk("b1_id", 32'(id), 32'd1);

        // Both requesting for three frames: grants alternate starting with 0.
        req_word0_8 = 8'h5B;
        req_word1_8 = 8'h0B;
        req_valid8  = 2'b11;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        exp_h[0] = 4'd2;  exp_h[1] = 4'd1;  exp_h[2] = 4'd2;
        t_prev = -1;
        for (int f = 0; f < 3; f++) begin
            wait_accept(t0, g);
            chk("c_grant", 32'(g), 32'(exp_g[f]));
            if (t_prev >= 0) chk("c_gap", 32'(t0 - t_prev), 32'd12);
            t_prev = t0;
            wait_done(td, h, id);
            chk("c_hits", 32'(h), 32'(exp_h[f]));
            chk("c_id", 32'(id), 32'(exp_g[f][1]));
        end
        req_valid8 = 2'b00;

        // Reset during the SHIFT cycle at t0+5 aborts the frame silently.
        req_word0_8 = 8'b1011_0110;
        req_valid8  = 2'b01;
        wait_accept(t0, g);
        req_valid8 = 2'b00;
        while (cyc != t0 + 5) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        dc = done_cnt;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("r_outputs", {req_ready8, ser_bit8, ser_en8, det_clr8, done8, done_id8, hit_count8},
            32'd0);
        repeat (14) @(posedge clock);
        #1;
        chk("r_no_done", 32'(done_cnt - dc), 32'd0);
        req_valid8 = 2'b01;
        wait_accept(t0, g);
        req_valid8 = 2'b00;
        chk("r_grant", 32'(g), 32'h1);
        wait_done(td, h, id);
        chk("r_latency", 32'(td - t0), 32'd11);
        chk("r_hits", 32'(h), 32'd2);

        // Requests and word changes while a frame is in flight are ignored.
        req_word0_8 = 8'h0B;
        req_valid8  = 2'b01;
        wait_accept(t0, g);
        rc = ready_cnt;
        req_valid8  = 2'b00;
        req_word0_8 = 8'hFF;
        repeat (2) @(posedge clock);
        #1;
        req_valid8  = 2'b10;
        req_word1_8 = 8'hB6;
        repeat (4) @(posedge clock);
        #1;
        req_valid8 = 2'b00;
        wait_done(td, h, id);
        chk("d_no_ready", 32'(ready_cnt - rc), 32'd0);
        chk("d_latency", 32'(td - t0), 32'd11);
        chk("d_hits", 32'(h), 32'd1);
        chk("d_id", 32'(id), 32'd0);

        // 16-bit frame with four matches saturates a 2-bit counter.
        req_word0_16 = 16'b1011_1011_1011_1011;
        req_valid16  = 2'b01;
        t0 = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (req_ready16 != 2'b00) begin
                t0 = cyc;
                break;
            end
        end
        if (t0 < 0) chk("w16_accept_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
        req_valid16 = 2'b00;
        td = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done16) begin
                td = cyc;
                h  = {2'b00, hit_count16};
                id = done_id16;
                break;
            end
        end
        if (td < 0) begin
            chk("w16_done_timeout", 32'd0, 32'd1);
        end else begin
            chk("w16_latency", 32'(td - t0), 32'd19);
            chk("w16_hits_sat", 32'(h), 32'd3);
            chk("w16_id", 32'(id), 32'd0);
        end

        repeat (3) @(posedge clock);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seqdet_sched.md
# seqdet_sched

Round-robin scheduler and sequencer that shares one bit-serial Moore "1011" sequence detector between two parallel-word requesters. It accepts a WORD_W-bit word from the granted requester and clears the detector. It then shifts the word into the detector MSB first, counts the detector hits over the frame, and reports the count with the requester id. It sits between the requesters and the detector instance, and owns the detector's serial input and its reset.

## Interface
- WORD_W, 8, frame length in bits (≥ 4)
- CNT_W, 4, width of hit counter (saturating)

- clock  in  1  single system clock; all state on rising edge
- reset  in  1  synchronous, active-high; the controller's only reset
- req_valid  in  2  per-requester request; held with word until accepted
- req_word0  in  WORD_W  requester 0 word
- req_word1  in  WORD_W  requester 1 word
- req_ready  out  2  one-hot, one-cycle accept strobe
- ser_bit  out  1  to detector sequence_in
- ser_en  out  1  high while a frame bit is on ser_bit
- det_clr  out  1  to detector reset; one-cycle pulse before each frame
- det_in  in  1  detector_out (Moore, registered state)
- done  out  1  one-cycle result strobe
- done_id  out  1  requester id of the finished frame
- hit_count  out  CNT_W  hits in the finished frame

## Operation
- Interface decision: one clock; reset is synchronous and active-high. Ports are named `clock` and `reset`.
- FSM states: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE:
  - If any req_valid is high, grant one requester and assert its req_ready bit for that cycle.
  - Latch its word and id into word_q and id_q, then go to CLEAR.
  - Otherwise stay in IDLE.
- Arbitration:
  - If one request is valid, grant it.
  - If both are valid, grant the requester that was not granted last (last_id). last_id updates on every grant.
- CLEAR: det_clr=1 for exactly one cycle; bit_idx←WORD_W-1; run counter←0; go to SHIFT.
- SHIFT: lasts WORD_W cycles.
  - ser_en=1 and ser_bit=word_q[bit_idx].
  - bit_idx decrements each cycle. After bit 0 is driven, go to DRAIN.
- Hit sampling:
  - det_in is sampled in SHIFT cycles 2..WORD_W and in the DRAIN cycle, for exactly WORD_W samples.
  - Each sample with det_in=1 increments the run counter.
  - The counter saturates at 2^CNT_W-1 and does not wrap.
  - The first SHIFT cycle is not sampled; the detector has just been cleared.
- DRAIN: ser_en=0 and ser_bit=0; take the last sample; go to DONE.
- DONE: done=1; hit_count←run counter; done_id←id_q; go to IDLE.
- hit_count and done_id hold their value until the next DONE.
- Outside SHIFT, ser_bit=0 and ser_en=0.
- req_ready is only ever asserted in IDLE. A requester's req_valid is ignored while a frame is in flight.
- The detector's overlapping-match behaviour is unchanged; the controller only counts the cycles in which det_in is high.

## Timing
- Reset values:
  - FSM=IDLE, last_id=1 (so requester 0 wins the first tie).
  - req_ready=0, ser_bit=0, ser_en=0, det_clr=0, done=0, done_id=0, hit_count=0.
- Cycle-level timing, with accept cycle = t0:
  - CLEAR at t0+1.
  - SHIFT at t0+2 .. t0+WORD_W+1.
  - DRAIN at t0+WORD_W+2.
  - done at t0+WORD_W+3. For WORD_W=8 this is t0+11.
- Earliest next accept is t0+WORD_W+4. There is no back-to-back overlap.
- Reset mid-frame: on the next edge the controller returns to IDLE with all outputs at reset values.
  - A partial frame produces no done.
  - A pending requester is re-arbitrated afresh.
- Simultaneous req_valid=2'b11 with done in the same cycle cannot occur (DONE→IDLE). The new grant happens in the IDLE cycle that follows.
- det_clr is asserted combinationally in CLEAR only. The detector is therefore in its Zero state before the first SHIFT bit is clocked.

## Test plan
- After reset, req_valid=01, req_word0=8'b1011_0110:
  - req_ready=01 at t0, det_clr at t0+1.
  - ser_bit sequence 1,0,1,1,0,1,1,0.
  - done at t0+11 with hit_count=2 and done_id=0 (overlapping match).
- req_word1=8'h00 and then 8'hFF on requester 1: hit_count=0 both times, done_id=1.
- req_valid=11 held across three frames: grants alternate 0,1,0. The first grant goes to 0, and each done_id matches its grant.
- Assert reset during the SHIFT cycle at t0+5:
  - The next cycle is IDLE with every output 0 and no done.
  - The re-issued request completes normally.
- Use WORD_W=16, CNT_W=2 with word 16'b1011_1011_1011_1011 (4 hits): hit_count saturates at 3.
- Drop req_valid while a frame is in flight: no extra req_ready, and the in-flight frame completes unchanged.
